nonce_collector: RTL and testbench

Parametrised, multi-channel successor to the single-channel nonce output stage. It collects found nonces from NUM_CH hashing cores, each presenting single-cycle valid pulses. Each channel's nonce is held in a per-channel pending register, arbitrated round-robin into a DEPTH-entry FIFO, and presented downstream with a valid/ready handshake. It also provides sticky `finished` and `overflow` status and a FIFO fill level. It sits between the hashing cores and the host/UART reporting logic.

---
 rtl/nonce_collector_pkg.sv | 19 +
 rtl/nonce_fifo.sv | 61 ++++++
 rtl/nonce_collector.sv | 118 +++++++++++
 tb/tb_nonce_collector.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/nonce_collector_pkg.sv
// Shared defaults, FIFO entry layout and the round-robin index helper for nonce_collector.
package nonce_collector_pkg;

  localparam int NUM_CH_DEF  = 4;
  localparam int NONCE_W_DEF = 32;
  localparam int DEPTH_DEF   = 8;
  localparam int CH_W_DEF    = (NUM_CH_DEF > 2) ? $clog2(NUM_CH_DEF) : 1;

  typedef struct packed {
    logic [CH_W_DEF-1:0]    ch;
    logic [NONCE_W_DEF-1:0] nonce;
  } fifo_entry_t;

  // Channel reached after stepping 'off' places past 'base' on a ring of n channels.
  function automatic int rr_index(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/nonce_fifo.sv
// Synchronous FIFO with registered storage and occupancy counter.
// Push is ignored when full unless a pop happens in the same cycle; pop is ignored when empty.
module nonce_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW    = (DEPTH > 2) ? $clog2(DEPTH) : 1,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == LVL_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];
  assign level   = count;

  // Storage has no reset; the head is only meaningful while count is non-zero.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + LVL_W'(1);
      end else if (!do_push && do_pop) begin
        count <= count - LVL_W'(1);
      end
    end
  end

endmodule

// File: rtl/nonce_collector.sv
// Collects nonces from NUM_CH cores via per-channel pending registers, a round-robin
// arbiter and a FIFO with a valid/ready output; sticky finished/overflow status.
module nonce_collector
  import nonce_collector_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int NONCE_W = NONCE_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  localparam int CH_W   = (NUM_CH > 2) ? $clog2(NUM_CH) : 1,
  localparam int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic [NUM_CH-1:0]         valid,
  input  logic [NUM_CH*NONCE_W-1:0] nonce,
  input  logic                      ready,
  output logic [NONCE_W-1:0]        nonce_out,
  output logic [CH_W-1:0]           ch_out,
  output logic                      valid_sal,
  output logic                      finished,
  output logic                      overflow,
  output logic [LVL_W-1:0]          level
);

  localparam int ENTRY_W = CH_W + NONCE_W;

  logic                 srst;
  logic [NUM_CH-1:0]    pend_vld;
  logic [NONCE_W-1:0]   pend_dat [NUM_CH];
  logic [CH_W-1:0]      rr_ptr;

  logic                 grant_vld;
  logic [CH_W-1:0]      grant_ch;
  logic [NUM_CH-1:0]    grant_oh;
  logic [NONCE_W-1:0]   grant_dat;
  logic                 can_push;

  logic                 fifo_pop;
  logic [ENTRY_W-1:0]   fifo_wdata;
  logic [ENTRY_W-1:0]   fifo_rdata;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [LVL_W-1:0]     fifo_level;

  assign srst     = reset | clear;
  assign fifo_pop = !fifo_empty && ready;
  // A pop in the same cycle frees the slot the grant is about to fill.
  assign can_push = !fifo_full || fifo_pop;

  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    grant_oh  = '0;
    grant_dat = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!grant_vld && can_push && pend_vld[rr_index(int'(rr_ptr), k, NUM_CH)]) begin
        grant_vld = 1'b1;
        grant_ch  = CH_W'(rr_index(int'(rr_ptr), k, NUM_CH));
        grant_oh[rr_index(int'(rr_ptr), k, NUM_CH)] = 1'b1;
        grant_dat = pend_dat[rr_index(int'(rr_ptr), k, NUM_CH)];
      end
    end
  end

  assign fifo_wdata = {grant_ch, grant_dat};

  always_ff @(posedge clk) begin
    if (srst) begin
      pend_vld <= '0;
      rr_ptr   <= CH_W'(NUM_CH - 1);
      finished <= 1'b0;
      overflow <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        pend_dat[i] <= '0;
      end
    end else begin
      if (grant_vld) begin
        rr_ptr   <= grant_ch;
        finished <= 1'b1;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (valid[i] && (!pend_vld[i] || grant_oh[i])) begin
          pend_vld[i] <= 1'b1;
          pend_dat[i] <= nonce[i*NONCE_W +: NONCE_W];
        end else begin
          if (valid[i]) begin
            overflow <= 1'b1;
          end
          if (grant_oh[i]) begin
            pend_vld[i] <= 1'b0;
          end
        end
      end
    end
  end

  nonce_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (srst),
    .push  (grant_vld),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  assign valid_sal = !fifo_empty;
  assign nonce_out = fifo_empty ? '0 : fifo_rdata[NONCE_W-1:0];
  assign ch_out    = fifo_empty ? '0 : fifo_rdata[ENTRY_W-1 -: CH_W];
  assign level     = fifo_level;

endmodule

// File: tb/tb_nonce_collector.sv
// Directed bench for nonce_collector with default parameters (4 channels, 32-bit nonce, depth 8).
module tb_nonce_collector;

  logic         clk = 1'b0;
  logic         reset;
  logic         clear;
  logic [3:0]   valid;
  logic [127:0] nonce;
  logic         ready;
  logic [31:0]  nonce_out;
  logic [1:0]   ch_out;
  logic         valid_sal;
  logic         finished;
  logic         overflow;
  logic [3:0]   level;

  int n_chk = 0;
  int n_bad = 0;

  nonce_collector dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .valid     (valid),
    .nonce     (nonce),
    .ready     (ready),
    .nonce_out (nonce_out),
    .ch_out    (ch_out),
    .valid_sal (valid_sal),
    .finished  (finished),
    .overflow  (overflow),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nonce(input int ch, input logic [31:0] v);
    nonce[ch*32 +: 32] = v;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_vld"},   64'(valid_sal), 64'd0);
    check_val({tag, "_nonce"}, 64'(nonce_out), 64'd0);
    check_val({tag, "_ch"},    64'(ch_out),    64'd0);
    check_val({tag, "_lvl"},   64'(level),     64'd0);
  endtask

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    valid = 4'b1111;
    nonce = '0;
    ready = 1'b0;
    for (int c = 0; c < 4; c++) set_nonce(c, 32'hA0 + 32'(c));
    step();
    step();
    check_idle("rst");
    check_val("rst_fin", 64'(finished), 64'd0);
    check_val("rst_ovf", 64'(overflow), 64'd0);

    // Round-robin: all four channels at once, drained in channel order.
    reset = 1'b0;
    ready = 1'b1;
    valid = 4'b1111;
    for (int c = 0; c < 4; c++) set_nonce(c, 32'd10 + 32'(c));
    step();
    valid = 4'b0000;
    check_val("rr_c1_vld", 64'(valid_sal), 64'd0);
    step();
    for (int c = 0; c < 4; c++) begin
      check_val("rr_vld",   64'(valid_sal), 64'd1);
      check_val("rr_ch",    64'(ch_out),    64'(c));
      check_val("rr_nonce", 64'(nonce_out), 64'(10 + c));
      check_val("rr_lvl",   64'(level),     64'd1);
      step();
    end
    check_idle("rr_end");
    check_val("rr_fin", 64'(finished), 64'd1);

    clear = 1'b1;
    step();
    clear = 1'b0;
    check_val("clr1_fin", 64'(finished), 64'd0);

    // Single nonce: two-cycle latency, then gone after one pop.
    valid = 4'b0100;
    set_nonce(2, 32'hDEADBEEF);
    step();
    valid = 4'b0000;
    step();
    check_val("one_vld",   64'(valid_sal), 64'd1);
    check_val("one_nonce", 64'(nonce_out), 64'hDEADBEEF);
    check_val("one_ch",    64'(ch_out),    64'd2);
    check_val("one_fin",   64'(finished),  64'd1);
    check_val("one_lvl",   64'(level),     64'd1);
    step();
    check_idle("one_after");
    check_val("one_fin_hold", 64'(finished), 64'd1);

    // Backpressure: nine staggered pulses, eight fill the FIFO, one waits in pending[0].
    clear = 1'b1;
    step();
    clear = 1'b0;
    ready = 1'b0;
    for (int p = 0; p < 9; p++) begin
      valid = 4'b0001 << (p % 4);
      set_nonce(p % 4, 32'd100 + 32'(p));
      step();
    end
    valid = 4'b0000;
    step();
    step();
    check_val("bp_lvl",   64'(level),     64'd8);
    check_val("bp_vld",   64'(valid_sal), 64'd1);
    check_val("bp_head",  64'(nonce_out), 64'd100);
    check_val("bp_hch",   64'(ch_out),    64'd0);
    check_val("bp_ovf",   64'(overflow),  64'd0);

    // Drop: ch1 pulses twice while the FIFO is full; the second nonce is lost.
    valid = 4'b0010;
    set_nonce(1, 32'd5);
    step();
    set_nonce(1, 32'd6);
    step();
    valid = 4'b0000;
    check_val("drop_ovf",  64'(overflow),  64'd1);
    check_val("drop_lvl",  64'(level),     64'd8);
    check_val("drop_head", 64'(nonce_out), 64'd100);

    ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      check_val("drain_vld",   64'(valid_sal), 64'd1);
      check_val("drain_nonce", 64'(nonce_out), (j < 9) ? 64'(100 + j) : 64'd5);
      check_val("drain_ch",    64'(ch_out),    (j < 9) ? 64'(j % 4) : 64'd1);
      step();
    end
    check_idle("drain_end");
    check_val("drain_ovf", 64'(overflow), 64'd1);
    check_val("drain_fin", 64'(finished), 64'd1);

    // Clear mid-operation with a pulse in the same cycle.
    ready = 1'b0;
    valid = 4'b0111;
    set_nonce(0, 32'd1);
    set_nonce(1, 32'd2);
    set_nonce(2, 32'd3);
    step();
    valid = 4'b0000;
    step();
    step();
    step();
    check_val("pre_clr_lvl", 64'(level),    64'd3);
    check_val("pre_clr_fin", 64'(finished), 64'd1);
    check_val("pre_clr_ovf", 64'(overflow), 64'd1);
    clear = 1'b1;
    valid = 4'b0001;
    set_nonce(0, 32'd0);
    step();
    clear = 1'b0;
    valid = 4'b0000;
    check_idle("clr");
    check_val("clr_fin", 64'(finished), 64'd0);
    check_val("clr_ovf", 64'(overflow), 64'd0);
    ready = 1'b1;
    step();
    step();
    step();
    check_idle("clr_late");
    check_val("clr_late_fin", 64'(finished), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
